// File: rtl/fetch_unit_pkg.sv
// Shared widths, default bubble instruction and FSM encoding for the fetch stage.
package fetch_unit_pkg;
  localparam int unsigned PC_W    = 13;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } state_e;
endpackage

// File: rtl/fetch_unit_ifid.sv
// IF/ID pipeline register: loads a fetched instruction, inserts a bubble, or holds.
module ifid_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic               hold_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_plus1_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_plus1_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_plus1_q, pc_plus1_d;
  logic               valid_q, valid_d;

  // A bubble leaves pc_plus1 untouched; it is meaningless while valid is low.
  always_comb begin
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    if (bubble_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (hold_i) begin
      instr_d    = instr_q;
      pc_plus1_d = pc_plus1_q;
      valid_d    = valid_q;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_plus1_d = pc_plus1_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, RUN/HALT control, delivered-instruction counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 13'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_target,
  input  logic                halt_req,
  output logic [PC_W-1:0]     pc,
  input  logic [INSTR_W-1:0]  instr_in,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic [PC_W-1:0]     ifid_pc_plus1,
  output logic                ifid_valid,
  output logic                halted,
  output logic [31:0]         fetch_count
);

  state_e        state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [31:0]   count_q, count_d;
  logic          halted_q, halted_d;
  logic          ld, bub, hld;

  assign pc_inc = pc_q + 1'b1;

  // One action per RUN cycle: halt > redirect > stall > advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    ld      = 1'b0;
    bub     = 1'b0;
    hld     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (halt_req) begin
          state_d = StHalt;
          bub     = 1'b1;
        end else if (redirect_valid) begin
          pc_d = redirect_target;
          bub  = 1'b1;
        end else if (stall) begin
          hld = 1'b1;
        end else begin
          pc_d    = pc_inc;
          count_d = count_q + 32'd1;
          ld      = 1'b1;
        end
      end
      StHalt: bub = 1'b1;
      default: ;
    endcase
    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (ld),
    .bubble_i   (bub),
    .hold_i     (hld),
    .instr_i    (instr_in),
    .pc_plus1_i (pc_inc),
    .instr_o    (ifid_instr),
    .pc_plus1_o (ifid_pc_plus1),
    .valid_o    (ifid_valid)
  );

  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, halt_req;
  logic [12:0] redirect_target;
  logic [12:0] pc;
  logic [31:0] instr_in;
  logic [31:0] ifid_instr;
  logic [12:0] ifid_pc_plus1;
  logic        ifid_valid, halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:8191];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory reads on the falling edge.
  always @(negedge clk) instr_in <= mem[pc];

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .pc              (pc),
    .instr_in        (instr_in),
    .ifid_instr      (ifid_instr),
    .ifid_pc_plus1   (ifid_pc_plus1),
    .ifid_valid      (ifid_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: one action per edge by priority.
  bit          m_init = 1'b0;
  bit          m_halted;
  bit          m_valid;
  logic [12:0] m_pc, m_ppc;
  logic [31:0] m_instr, m_count;

  always @(posedge clk) begin
    if (reset) begin
      m_init <= 1'b1; m_halted <= 1'b0; m_valid <= 1'b0;
      m_pc <= 13'h0; m_ppc <= 13'h0; m_instr <= 32'h0; m_count <= 32'h0;
    end else if (m_halted) begin
      m_instr <= 32'h0; m_valid <= 1'b0;
    end else if (halt_req) begin
      m_halted <= 1'b1; m_instr <= 32'h0; m_valid <= 1'b0;
    end else if (redirect_valid) begin
      m_pc <= redirect_target; m_instr <= 32'h0; m_valid <= 1'b0;
    end else if (!stall) begin
      m_instr <= mem[m_pc];
      m_ppc   <= m_pc + 13'd1;
      m_pc    <= m_pc + 13'd1;
      m_valid <= 1'b1;
      m_count <= m_count + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_pc", pc, m_pc);
      chk("model_instr", ifid_instr, m_instr);
      chk("model_valid", ifid_valid, m_valid);
      chk("model_halted", halted, m_halted);
      chk("model_count", fetch_count, m_count);
      if (m_valid) chk("model_pc_plus1", ifid_pc_plus1, m_ppc);
    end
  end

  task automatic tick(input logic r, input logic s, input logic rv, input logic [12:0] rt,
                      input logic h);
    reset = r; stall = s; redirect_valid = rv; redirect_target = rt; halt_req = h;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic adv();
    tick(1'b0, 1'b0, 1'b0, 13'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h1000_0000 + i;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 13'h0; halt_req = 1'b0;
    @(negedge clk);

    // Reset state, then sequential fetch.
    tick(1'b1, 1'b1, 1'b1, 13'h0555, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc_plus1", ifid_pc_plus1, 32'h0);
    chk("rst_valid", ifid_valid, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_halted", halted, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      adv();
      chk("seq_instr", ifid_instr, 32'h1000_0000 + k - 1);
      chk("seq_pc_plus1", ifid_pc_plus1, k);
    end
    chk("seq_count", fetch_count, 32'd5);
    chk("seq_pc", pc, 32'd5);

    // Redirect at cycle 3.
    tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b0);
    adv();
    adv();
    tick(1'b0, 1'b0, 1'b1, 13'h0100, 1'b0);
    chk("redir_valid", ifid_valid, 32'h0);
    chk("redir_instr", ifid_instr, 32'h0);
    chk("redir_count", fetch_count, 32'd2);
    chk("redir_pc", pc, 32'h0100);
    adv();
    chk("redir_target_instr", ifid_instr, 32'h1000_0100);
    chk("redir_count_after", fetch_count, 32'd3);

    // Stall freezes everything; redirect beats stall.
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1, 1'b0, 13'h0, 1'b0);
      chk("stall_instr", ifid_instr, 32'h1000_0100);
      chk("stall_valid", ifid_valid, 32'h1);
      chk("stall_pc", pc, 32'h0101);
      chk("stall_count", fetch_count, 32'd3);
    end
    tick(1'b0, 1'b1, 1'b1, 13'h0020, 1'b0);
    chk("stall_redir_pc", pc, 32'h0020);
    chk("stall_redir_valid", ifid_valid, 32'h0);
    adv();
    chk("stall_redir_instr", ifid_instr, 32'h1000_0020);

    // PC wrap.
    tick(1'b0, 1'b0, 1'b1, 13'h1FFE, 1'b0);
    adv();
    chk("wrap_pp1_a", ifid_pc_plus1, 32'h1FFF);
    adv();
    chk("wrap_pp1_b", ifid_pc_plus1, 32'h0000);
    chk("wrap_pc", pc, 32'h0000);
    chk("wrap_instr", ifid_instr, 32'h1000_1FFF);
    adv();
    chk("wrap_pp1_c", ifid_pc_plus1, 32'h0001);

    // Halt at cycle 4, ignore everything, exit on reset.
    tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b0);
    adv();
    adv();
    adv();
    tick(1'b0, 1'b0, 1'b0, 13'h0, 1'b1);
    chk("halt_halted", halted, 32'h1);
    chk("halt_valid", ifid_valid, 32'h0);
    chk("halt_pc", pc, 32'h3);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, k[0], 1'b1, 13'h0777, k[1]);
      chk("halt_hold_pc", pc, 32'h3);
      chk("halt_hold_halted", halted, 32'h1);
      chk("halt_hold_instr", ifid_instr, 32'h0);
    end
    chk("halt_count", fetch_count, 32'd3);
    tick(1'b1, 1'b0, 1'b0, 13'h0, 1'b0);
    chk("halt_rst_halted", halted, 32'h0);
    adv();
    chk("halt_rst_instr", ifid_instr, 32'h1000_0000);
    chk("halt_rst_valid", ifid_valid, 32'h1);

    // Random traffic, model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic [12:0] rt;
      rt = 13'($urandom);
      if ($urandom_range(3) == 0) rt = 13'h1FF0 | 13'($urandom_range(15));
      tick($urandom_range(63) == 0, $urandom_range(4) == 0, $urandom_range(7) == 0, rt,
           $urandom_range(149) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
